// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: parameter defaults
// and the clear-sequencer state encoding.
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREG_DEF   = 32;
    localparam int NRP_DEF    = 2;
    localparam int BYPASS_DEF = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// Clear sequencer: sweeps registers 1..NREG-1 to zero, one per cycle.
// Register 0 is hardwired to zero, so the sweep starts at index 1.
module regfile_clr_fsm
    import regfile_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output clr_state_e    state,
    output logic          clr_busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_idx
);

    clr_state_e    state_nxt;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            idx      <= '0;
            clr_busy <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            clr_busy <= (state_nxt == CLEAR);
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        clr_we    = 1'b0;
        clr_idx   = idx;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = AW'(1);
                end
            end
            CLEAR: begin
                // clr_req is deliberately ignored here: no queuing, no restart.
                clr_we = 1'b1;
                if (idx == AW'(NREG - 1)) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + AW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with x0 hardwired to zero, optional
// write-to-read forwarding and a sequential whole-file clear.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int NRP    = NRP_DEF,
    parameter int BYPASS = BYPASS_DEF,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rd_en,
    input  logic [NRP*AW-1:0]   rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic                rd_valid,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    output logic                wr_ready,
    input  logic                clr_req,
    output logic                clr_busy
);

    // Handshake: a write is taken at a rising edge where wr_en && wr_ready;
    // otherwise it is dropped (no buffering). Reads have no backpressure.

    clr_state_e    clr_state;
    logic          clr_we;
    logic [AW-1:0] clr_idx;
    logic          wr_fire;
    logic [XLEN-1:0] regs [NREG];

    regfile_clr_fsm #(
        .NREG (NREG),
        .AW   (AW)
    ) u_clr_fsm (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .state    (clr_state),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_idx  (clr_idx)
    );

    assign wr_ready = (clr_state == IDLE);
    assign wr_fire  = wr_en && wr_ready && (wr_addr != '0);

    // The clear and a write never collide: writes are only taken in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_we) begin
            regs[clr_idx] <= '0;
        end else if (wr_fire) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
        end
    end

    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data_q;

        assign addr = rd_addr[k*AW +: AW];

        always_ff @(posedge clk) begin
            if (!rst) begin
                data_q <= '0;
            end else if (rd_en) begin
                if (addr == '0) begin
                    data_q <= '0;
                end else if ((BYPASS != 0) && wr_fire && (wr_addr == addr)) begin
                    data_q <= wr_data;
                end else begin
                    data_q <= regs[addr];
                end
            end
        end

        assign rd_data[k*XLEN +: XLEN] = data_q;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances (forwarding on and off)
// share all stimulus; every check is an immediate assertion.
module tb_regfile_mp;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRP  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                rd_en = 1'b0;
    logic [NRP*AW-1:0]   rd_addr = '0;
    logic                wr_en = 1'b0;
    logic [AW-1:0]       wr_addr = '0;
    logic [XLEN-1:0]     wr_data = '0;
    logic                clr_req = 1'b0;

    logic [NRP*XLEN-1:0] rd_data_b, rd_data_n;
    logic                rd_valid_b, rd_valid_n;
    logic                wr_ready_b, wr_ready_n;
    logic                clr_busy_b, clr_busy_n;

    int checks = 0;
    int errors = 0;
    int count;
    logic [XLEN-1:0] exp_q[$];
    logic [XLEN-1:0] e;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready_b),
        .clr_req(clr_req), .clr_busy(clr_busy_b)
    );

    regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_n), .rd_valid(rd_valid_n), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready_n),
        .clr_req(clr_req), .clr_busy(clr_busy_n)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en   = 1'b1;
        rd_addr = {a1, a0};
        step();
        rd_en   = 1'b0;
    endtask

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [XLEN-1:0] obs,
                       input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_both(input string tag, input logic [XLEN-1:0] e0,
                            input logic [XLEN-1:0] e1);
        chk({tag, "_b_p0"}, rd_data_b[31:0],  e0);
        chk({tag, "_b_p1"}, rd_data_b[63:32], e1);
        chk({tag, "_n_p0"}, rd_data_n[31:0],  e0);
        chk({tag, "_n_p1"}, rd_data_n[63:32], e1);
    endtask

    initial begin
        // Reset state
        rst = 1'b0;
        step();
        step();
        chk("rst_rd_valid", {31'd0, rd_valid_b}, 32'd0);
        chk("rst_clr_busy", {31'd0, clr_busy_b}, 32'd0);
        chk_both("rst_rd_data", 32'd0, 32'd0);
        rst = 1'b1;
        step();
        chk("wr_ready_after_rst", {31'd0, wr_ready_b}, 32'd1);

        // Write then read
        do_write(5'd5, 32'hDEADBEEF);
        do_read(5'd5, 5'd1);
        chk_both("wr_rd_5", 32'hDEADBEEF, 32'd0);
        chk("wr_rd_valid", {31'd0, rd_valid_b}, 32'd1);
        step();
        chk("rd_idle_valid", {31'd0, rd_valid_b}, 32'd0);
        chk_both("rd_idle_hold", 32'hDEADBEEF, 32'd0);

        // Register 0 hardwired
        do_write(5'd0, 32'h12345678);
        do_read(5'd0, 5'd0);
        chk_both("x0_read", 32'd0, 32'd0);

        // Same-cycle write/read of address 7: forwarding vs old value
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
        rd_en = 1'b1; rd_addr = {5'd5, 5'd7};
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk("bypass_on_p0",  rd_data_b[31:0],  32'hA5A5A5A5);
        chk("bypass_off_p0", rd_data_n[31:0],  32'h0);
        chk("bypass_on_p1",  rd_data_b[63:32], 32'hDEADBEEF);
        chk("bypass_off_p1", rd_data_n[63:32], 32'hDEADBEEF);
        do_read(5'd7, 5'd7);
        chk_both("after_bypass_7", 32'hA5A5A5A5, 32'hA5A5A5A5);

        // Forwarding must not apply to address 0
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        rd_en = 1'b1; rd_addr = {5'd0, 5'd0};
        step();
        wr_en = 1'b0; rd_en = 1'b0;
        chk_both("bypass_x0", 32'd0, 32'd0);

        // Full clear sweep
        for (int a = 1; a < NREG; a++) do_write(AW'(a), XLEN'(a));
        do_read(5'd3, 5'd31);
        chk_both("fill_3_31", 32'd3, 32'd31);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        chk("clr_busy_start", {31'd0, clr_busy_b}, 32'd1);
        chk("wr_ready_clear", {31'd0, wr_ready_b}, 32'd0);
        count = 0;
        while (clr_busy_b === 1'b1 && count < 100) begin
            count++;
            if (count == 5) begin
                wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h00000BAD;
                chk("wr_ready_mid_clear", {31'd0, wr_ready_n}, 32'd0);
            end
            if (count == 8) clr_req = 1'b1;
            if (count == 10) begin
                rd_en = 1'b1; rd_addr = {5'd30, 5'd2};
            end
            if (count == 11) begin
                chk_both("mid_clear_read", 32'd0, 32'd30);
                chk("mid_clear_valid", {31'd0, rd_valid_b}, 32'd1);
            end
            step();
            wr_en = 1'b0; clr_req = 1'b0; rd_en = 1'b0;
        end
        chk("clr_busy_cycles", 32'(count), 32'd31);
        chk("clr_busy_n_done", {31'd0, clr_busy_n}, 32'd0);
        chk("wr_ready_after_clear", {31'd0, wr_ready_b}, 32'd1);
        for (int a = 0; a < 16; a++) begin
            exp_q.push_back(32'd0);
            exp_q.push_back(32'd0);
            do_read(AW'(a), AW'(a + 16));
            e = exp_q.pop_front();
            chk($sformatf("clr_rd_%0d", a), rd_data_b[31:0], e);
            e = exp_q.pop_front();
            chk($sformatf("clr_rd_%0d", a + 16), rd_data_n[63:32], e);
        end

        // Reset in the middle of a sweep
        do_write(5'd4, 32'd4);
        do_write(5'd20, 32'd20);
        do_write(5'd31, 32'd31);
        do_read(5'd20, 5'd31);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 9; i++) step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_mid_busy", {31'd0, clr_busy_b}, 32'd0);
        chk("rst_mid_valid", {31'd0, rd_valid_b}, 32'd0);
        chk_both("rst_mid_data", 32'd0, 32'd0);
        chk("rst_mid_wr_ready", {31'd0, wr_ready_b}, 32'd1);
        do_read(5'd20, 5'd31);
        chk_both("rst_mid_regs", 32'd0, 32'd0);
        do_read(5'd4, 5'd5);
        chk_both("rst_mid_regs2", 32'd0, 32'd0);

        // Write and clear request in the same cycle
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h55;
        clr_req = 1'b1;
        step();
        wr_en = 1'b0; clr_req = 1'b0;
        chk("simul_busy", {31'd0, clr_busy_b}, 32'd1);
        do_read(5'd31, 5'd31);
        chk_both("simul_early", 32'h55, 32'h55);
        for (int i = 0; i < 18; i++) step();
        do_read(5'd31, 5'd1);
        chk_both("simul_late", 32'h55, 32'd0);
        count = 0;
        while (clr_busy_b === 1'b1 && count < 100) begin
            count++;
            step();
        end
        chk("simul_sweep_end", {31'd0, clr_busy_b}, 32'd0);
        do_read(5'd31, 5'd31);
        chk_both("simul_after", 32'd0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-002 SHALL have parameter NREG, default 32, meaning register count; must be a power of two and at least 2.
REQ-003 SHALL have parameter NRP, default 2, meaning number of read ports.
REQ-004 SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when 1.
REQ-005 SHALL have a derived constant AW = log2(NREG), meaning address width.
REQ-006 SHALL provide port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL provide port rst, input, 1 bit: reset, synchronous and active-low.
REQ-008 SHALL provide port rd_en, input, 1 bit: read strobe, shared by all read ports.
REQ-009 SHALL provide port rd_addr, input, NRP*AW bits: read addresses, with port k in bits [k*AW +: AW].
REQ-010 SHALL provide port rd_data, output, NRP*XLEN bits: registered read data, with port k in bits [k*XLEN +: XLEN].
REQ-011 SHALL provide port rd_valid, output, 1 bit: rd_data updated this cycle.
REQ-012 SHALL provide port wr_en, input, 1 bit: write strobe.
REQ-013 SHALL provide port wr_addr, input, AW bits: write address.
REQ-014 SHALL provide port wr_data, input, XLEN bits: write data.
REQ-015 SHALL provide port wr_ready, output, 1 bit: writes accepted; combinational, high only in state IDLE.
REQ-016 SHALL provide port clr_req, input, 1 bit: request a sequential clear of the whole file.
REQ-017 SHALL provide port clr_busy, output, 1 bit: high while a clear sweep is in progress.

Function
REQ-018 SHALL hardwire register 0 to zero: reads of address 0 return 0, and writes to address 0 are discarded.
REQ-019 SHALL commit a write to wr_addr at the clock edge where wr_en and wr_ready are both 1; a write with wr_ready=0 is dropped, with no buffering.
REQ-020 SHALL have read latency 1: when rd_en=1 at edge N, rd_data shows the values at edge N+1 and rd_valid=1 for that cycle.
REQ-021 SHALL hold the previous rd_data value and drive rd_valid=0 when rd_en=0.
REQ-022 SHALL, when BYPASS=1 and a read port address equals a nonzero wr_addr of an accepted write in the same cycle, return wr_data on that port.
REQ-023 SHALL, when BYPASS=0 in the same situation, return the old register contents on that port.
REQ-024 SHALL implement a state machine with two states: IDLE and CLEAR.
REQ-025 SHALL move from IDLE to CLEAR when clr_req=1, loading the sweep index with 1.
REQ-026 SHALL, in CLEAR, zero register[index] each cycle and increment index; after index NREG-1 is zeroed it returns to IDLE, so CLEAR lasts exactly NREG-1 cycles.
REQ-027 SHALL ignore clr_req while in state CLEAR; there is no queuing and no restart.
REQ-028 SHALL keep reads enabled during CLEAR: registers already swept read as 0 and registers not yet swept read their old value.
REQ-029 SHALL drive clr_busy = (state == CLEAR), registered.
REQ-030 SHALL, when a write and clr_req both occur in the same IDLE cycle, commit the write and then enter CLEAR, so the written value is later zeroed.

Reset
REQ-031 SHALL, on rst=0 at a clock edge, zero all registers, set rd_data to 0, rd_valid to 0, state to IDLE, clr_busy to 0 and index to 0.
REQ-032 SHALL give reset priority over all other inputs, including when asserted mid-CLEAR, where it aborts the sweep and returns to IDLE.
REQ-033 SHALL drive wr_ready=1 from the first cycle after reset is released.

Structure
REQ-034 SHALL place the state encoding (IDLE=0, CLEAR=1) and the parameter defaults in shared package regfile_pkg.
REQ-035 SHALL contain one sub-module, regfile_clr_fsm, holding the state, sweep index and clr_busy, with outputs clr_we and clr_idx.
REQ-036 SHALL instantiate the read port logic with a generate loop over NRP, with no per-port copies written by hand.

Verification
REQ-037 SHALL verify write/read: write 0xDEADBEEF to address 5, then next cycle read port 0 at address 5 -> rd_data port 0 is 0xDEADBEEF one cycle later with rd_valid=1.
REQ-038 SHALL verify x0: write 0x12345678 to address 0, then read address 0 on both ports -> both return 0x00000000.
REQ-039 SHALL verify bypass: in the same cycle write 0xA5A5A5A5 to address 7 and read address 7 -> 0xA5A5A5A5 when BYPASS=1, and the previous value 0x0 when BYPASS=0.
REQ-040 SHALL verify clear: fill addresses 1-31 with their own index, pulse clr_req -> clr_busy high for 31 cycles, wr_ready low, a write to address 3 mid-sweep dropped, and all reads 0 afterwards.
REQ-041 SHALL verify reset mid-clear: assert rst=0 at sweep cycle 10 -> next cycle clr_busy=0, rd_valid=0 and all registers read 0.
REQ-042 SHALL verify the simultaneous case: write 0x55 to address 31 in the same cycle as clr_req -> address 31 reads 0x55 during the first 29 sweep cycles and 0 after the sweep.
